// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2/stride-2 pooling engine: FSM encodings,
// pooling mode codes and default DRAM base addresses.
package pool_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LD_CFG = 3'd1,
    ST_RD     = 3'd2,
    ST_WR     = 3'd3,
    ST_DONE   = 3'd4
  } pool_state_e;

  localparam logic POOL_MODE_MAX = 1'b0;
  localparam logic POOL_MODE_AVG = 1'b1;

  localparam int unsigned DEF_IFMAP_BASE = 131072;
  localparam int unsigned DEF_OFMAP_BASE = 65536;

endpackage

// File: rtl/pool_reduce.sv
// Beat-serial window reducer: running signed max or running sum of one 2x2 window.
// Results are taken from the next-state accumulator so the last beat is included.
module pool_reduce
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  clear_i,
  input  logic                  acc_en_i,
  input  logic                  first_i,
  input  logic                  mode_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] max_o,
  output logic [DATA_WIDTH-1:0] avg_o
);

  localparam int ACC_WIDTH = DATA_WIDTH + 2;

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, beat_ext;

  assign beat_ext = {{2{data_i[DATA_WIDTH-1]}}, data_i};

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (acc_en_i) begin
      if (first_i) begin
        acc_d = beat_ext;
      end else if (mode_i == POOL_MODE_AVG) begin
        acc_d = acc_q + beat_ext;
      end else if (beat_ext > acc_q) begin
        // strict compare: on a tie the earlier beat is kept
        acc_d = beat_ext;
      end
    end
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign max_o = acc_d[DATA_WIDTH-1:0];
  // sum >>> 2 truncated to DATA_WIDTH is exactly bits [DATA_WIDTH+1:2]
  assign avg_o = acc_d[DATA_WIDTH+1:2];

endmodule

// File: rtl/pool_engine.sv
// Runtime-configurable 2x2/stride-2 max/average pooling engine: reads the ifmap
// from DRAM with a valid handshake and writes the pooled ofmap back.
module pool_engine
  import pool_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 18,
  parameter int          DIM_WIDTH  = 5,
  parameter int          Z_WIDTH    = 4,
  parameter int unsigned IFMAP_BASE = DEF_IFMAP_BASE,
  parameter int unsigned OFMAP_BASE = DEF_OFMAP_BASE
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  enable,
  input  logic [DIM_WIDTH:0]    cfg_width,
  input  logic [DIM_WIDTH:0]    cfg_height,
  input  logic [Z_WIDTH:0]      cfg_depth,
  input  logic                  cfg_mode,
  input  logic                  dram_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic                  dram_en_rd,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  dram_en_wr,
  output logic                  busy,
  output logic                  done
);

  localparam int PACK_WIDTH = Z_WIDTH + 2 * DIM_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] IF_BASE = ADDR_WIDTH'(IFMAP_BASE);
  localparam logic [ADDR_WIDTH-1:0] OF_BASE = ADDR_WIDTH'(OFMAP_BASE);

  function automatic logic [ADDR_WIDTH-1:0] pack_addr(
    input logic [ADDR_WIDTH-1:0] base,
    input logic [Z_WIDTH-1:0]    z,
    input logic [DIM_WIDTH-1:0]  y,
    input logic [DIM_WIDTH-1:0]  x
  );
    logic [PACK_WIDTH-1:0] field;
    field = {z, y, x};
    return base + ADDR_WIDTH'(field);
  endfunction

  pool_state_e state_q, state_d;

  logic [DIM_WIDTH:0]   w_q, w_d, h_q, h_d;
  logic [Z_WIDTH:0]     d_q, d_d;
  logic                 mode_q, mode_d;
  logic [DIM_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [Z_WIDTH-1:0]   z_q, z_d;
  logic [1:0]           beat_q, beat_d;

  logic [ADDR_WIDTH-1:0] addr_in_q, addr_in_d, addr_out_q, addr_out_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  dram_en_rd_q, dram_en_rd_d, dram_en_wr_q, dram_en_wr_d;
  logic                  busy_q, busy_d, done_q, done_d;

  logic [DIM_WIDTH:0]    w_even, h_even;
  logic                  last_x, last_y, last_z, last_win, cfg_empty, beat_take;
  logic [DATA_WIDTH-1:0] max_res, avg_res;

  // odd dimensions floor: the trailing column/row is never visited
  assign w_even    = w_q & ~(DIM_WIDTH+1)'(1);
  assign h_even    = h_q & ~(DIM_WIDTH+1)'(1);
  assign last_x    = ({1'b0, x_q} == w_even - (DIM_WIDTH+1)'(2));
  assign last_y    = ({1'b0, y_q} == h_even - (DIM_WIDTH+1)'(2));
  assign last_z    = ({1'b0, z_q} == d_q - (Z_WIDTH+1)'(1));
  assign last_win  = last_x && last_y && last_z;
  assign cfg_empty = (w_q < (DIM_WIDTH+1)'(2)) || (h_q < (DIM_WIDTH+1)'(2)) ||
                     (d_q == '0);
  assign beat_take = (state_q == ST_RD) && dram_valid;

  pool_reduce #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_reduce (
    .clk     (clk),
    .srstn   (srstn),
    .clear_i (state_q == ST_LD_CFG),
    .acc_en_i(beat_take),
    .first_i (beat_q == 2'd0),
    .mode_i  (mode_q),
    .data_i  (data_in),
    .max_o   (max_res),
    .avg_o   (avg_res)
  );

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (enable) state_d = ST_LD_CFG;
      ST_LD_CFG: state_d = cfg_empty ? ST_DONE : ST_RD;
      ST_RD:     if (beat_take && beat_q == 2'd3) state_d = ST_WR;
      ST_WR:     state_d = last_win ? ST_DONE : ST_RD;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    w_d    = w_q;
    h_d    = h_q;
    d_d    = d_q;
    mode_d = mode_q;
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    beat_d = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          w_d    = cfg_width;
          h_d    = cfg_height;
          d_d    = cfg_depth;
          mode_d = cfg_mode;
        end
      end
      ST_LD_CFG: begin
        x_d    = '0;
        y_d    = '0;
        z_d    = '0;
        beat_d = '0;
      end
      ST_RD: if (beat_take) beat_d = beat_q + 2'd1;
      ST_WR: begin
        if (last_x) begin
          x_d = '0;
          if (last_y) begin
            y_d = '0;
            z_d = z_q + Z_WIDTH'(1);
          end else begin
            y_d = y_q + DIM_WIDTH'(2);
          end
        end else begin
          x_d = x_q + DIM_WIDTH'(2);
        end
      end
      default: ;
    endcase
  end

  // Outputs are derived from the next state so they line up with it once registered.
  always_comb begin
    addr_in_d    = addr_in_q;
    addr_out_d   = addr_out_q;
    data_out_d   = data_out_q;
    dram_en_rd_d = (state_d == ST_RD);
    dram_en_wr_d = (state_d == ST_WR);
    busy_d       = state_d inside {ST_LD_CFG, ST_RD, ST_WR};
    done_d       = (state_d == ST_DONE);
    if (state_d == ST_RD) begin
      addr_in_d = pack_addr(IF_BASE, z_d, y_d + DIM_WIDTH'(beat_d[1]),
                            x_d + DIM_WIDTH'(beat_d[0]));
    end
    if (state_d == ST_WR) begin
      addr_out_d = pack_addr(OF_BASE, z_q, y_q >> 1, x_q >> 1);
      data_out_d = (mode_q == POOL_MODE_MAX) ? max_res : avg_res;
    end
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      w_q    <= '0;
      h_q    <= '0;
      d_q    <= '0;
      mode_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      beat_q <= '0;
    end else begin
      w_q    <= w_d;
      h_q    <= h_d;
      d_q    <= d_d;
      mode_q <= mode_d;
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
      beat_q <= beat_d;
    end
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      addr_in_q    <= '0;
      dram_en_rd_q <= 1'b0;
      addr_out_q   <= '0;
      data_out_q   <= '0;
      dram_en_wr_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      addr_in_q    <= addr_in_d;
      dram_en_rd_q <= dram_en_rd_d;
      addr_out_q   <= addr_out_d;
      data_out_q   <= data_out_d;
      dram_en_wr_q <= dram_en_wr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign addr_in    = addr_in_q;
  assign dram_en_rd = dram_en_rd_q;
  assign addr_out   = addr_out_q;
  assign data_out   = data_out_q;
  assign dram_en_wr = dram_en_wr_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_pool_engine.sv
// Directed bench for pool_engine: a DRAM responder with optional random read
// latency plus a write monitor, and one task per scenario.
module tb_pool_engine;

  localparam int IFB = 131072;
  localparam int OFB = 65536;

  logic        clk = 1'b0;
  logic        srstn = 1'b1;
  logic        enable = 1'b0;
  logic [5:0]  cfg_width = '0;
  logic [5:0]  cfg_height = '0;
  logic [4:0]  cfg_depth = '0;
  logic        cfg_mode = 1'b0;
  logic        dram_valid = 1'b0;
  logic [31:0] data_in = '0;
  logic [17:0] addr_in, addr_out;
  logic [31:0] data_out;
  logic        dram_en_rd, dram_en_wr, busy, done;

  int tests = 0;
  int fails = 0;

  logic [31:0] dram [0:262143];

  bit          rand_lat = 1'b0;
  int          wait_cnt = 0;
  bit          have_req = 1'b0;
  logic [17:0] req_addr = '0;
  int          unstable = 0, stall_cycles = 0, beats = 0, rd_cycles = 0, bad_reads = 0;
  int          cyc = 0, last_wr_cyc = -1, done_cyc = -1;
  logic [17:0] wr_addr [$];
  logic [31:0] wr_data [$];
  logic [17:0] base_addr [$];
  logic [31:0] base_data [$];

  pool_engine dut (
    .clk       (clk),
    .srstn     (srstn),
    .enable    (enable),
    .cfg_width (cfg_width),
    .cfg_height(cfg_height),
    .cfg_depth (cfg_depth),
    .cfg_mode  (cfg_mode),
    .dram_valid(dram_valid),
    .data_in   (data_in),
    .addr_in   (addr_in),
    .dram_en_rd(dram_en_rd),
    .addr_out  (addr_out),
    .data_out  (data_out),
    .dram_en_wr(dram_en_wr),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // DRAM responder and write monitor, both working on the falling edge
  initial begin : dram_model
    forever begin
      @(negedge clk);
      cyc++;
      dram_valid = 1'b0;
      if (dram_en_wr) begin
        wr_addr.push_back(addr_out);
        wr_data.push_back(data_out);
        last_wr_cyc = cyc;
        $display("[TB] wr addr=%0d data=%0d", addr_out, $signed(data_out));
      end
      if (done) done_cyc = cyc;
      if (dram_en_rd) begin
        rd_cycles++;
        if (addr_in[4:0] == 5'd4 || addr_in[9:5] == 5'd4) bad_reads++;
        if (!have_req) begin
          have_req = 1'b1;
          req_addr = addr_in;
        end else if (addr_in !== req_addr) begin
          unstable++;
        end
        if (wait_cnt == 0) begin
          dram_valid = 1'b1;
          data_in    = dram[addr_in];
          have_req   = 1'b0;
          beats++;
          wait_cnt   = rand_lat ? int'($urandom_range(0, 7)) : 0;
        end else begin
          wait_cnt--;
          stall_cycles++;
        end
      end else begin
        if (have_req && srstn) unstable++;
        have_req = 1'b0;
      end
    end
  end

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    rd_cycles = 0; bad_reads = 0; beats = 0; unstable = 0; stall_cycles = 0;
    done_cyc = -1; last_wr_cyc = -1;
  endtask

  task automatic start_run(input int w, input int h, input int d, input bit mode);
    @(negedge clk);
    cfg_width = 6'(w); cfg_height = 6'(h); cfg_depth = 5'(d); cfg_mode = mode;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string name);
    int n = 0;
    while (!done && n < bound) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", name, done, bound);
    end
    @(negedge clk);
  endtask

  task automatic load_img4(input int img[16]);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        dram[IFB + y*32 + x] = img[y*4 + x];
  endtask

  function automatic int pix3(input int z, input int y, input int x);
    return ((x*5 + y*3 + z*7) % 11 - 5) * 1000003;
  endfunction

  function automatic logic [31:0] ref_pool(input int z, input int yb, input int xb, input bit avg);
    longint s = 0, m = 0, v;
    for (int b = 0; b < 4; b++) begin
      v = longint'($signed(dram[IFB + z*1024 + (yb + b/2)*32 + xb + b%2]));
      s += v;
      if (b == 0 || v > m) m = v;
    end
    return avg ? 32'(s >>> 2) : 32'(m);
  endfunction

  task automatic test_reset();
    #1 srstn = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({dram_en_rd, dram_en_wr, busy, done} !== 4'b0) begin
      fails++;
      $display("FAIL reset_strobes: rd/wr/busy/done=%b required 0000",
               {dram_en_rd, dram_en_wr, busy, done});
    end
    tests++;
    if (addr_in !== 18'd0 || addr_out !== 18'd0) begin
      fails++;
      $display("FAIL reset_addr: addr_in=%0d addr_out=%0d required 0", addr_in, addr_out);
    end
    tests++;
    if (data_out !== 32'd0) begin
      fails++;
      $display("FAIL reset_data: data_out=%0d required 0", data_out);
    end
    srstn = 1'b1;
  endtask

  task automatic test_max_basic();
    int          img[16] = '{-5, -2, 10, 3,  -9, -3, 4, 10,  0, 0, -1, -7,  0, -1, -8, -1};
    int          exp_a[4] = '{65536, 65537, 65568, 65569};
    int          exp_d[4] = '{-2, 10, 0, -1};
    load_img4(img);
    clear_mon();
    start_run(4, 4, 1, 1'b0);
    wait_done(2000, "max_basic");
    tests++;
    if (wr_addr.size() != 4) begin
      fails++;
      $display("FAIL max_wr_count: got %0d writes, required 4", wr_addr.size());
    end
    for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
      tests++;
      if (wr_addr[i] !== 18'(exp_a[i]) || wr_data[i] !== 32'(exp_d[i])) begin
        fails++;
        $display("FAIL max_wr%0d: addr=%0d data=%0d, required addr=%0d data=%0d",
                 i, wr_addr[i], $signed(wr_data[i]), exp_a[i], exp_d[i]);
      end
    end
    tests++;
    if (done_cyc != last_wr_cyc + 1) begin
      fails++;
      $display("FAIL max_done_timing: done at cycle %0d, required %0d", done_cyc, last_wr_cyc + 1);
    end
  endtask

  task automatic test_avg();
    int img[16] = '{7, -8, -1, -1,  1, 1, -1, -2,  100, 200, 2147483647, 2147483647,
                    300, 400, 2147483647, 2147483647};
    int exp_d[4] = '{0, -2, 250, 2147483647};
    load_img4(img);
    clear_mon();
    start_run(4, 4, 1, 1'b1);
    wait_done(2000, "avg");
    tests++;
    if (wr_data.size() != 4) begin
      fails++;
      $display("FAIL avg_wr_count: got %0d writes, required 4", wr_data.size());
    end
    for (int i = 0; i < 4 && i < wr_data.size(); i++) begin
      tests++;
      if (wr_data[i] !== 32'(exp_d[i])) begin
        fails++;
        $display("FAIL avg_wr%0d: data=%0d, required %0d", i, $signed(wr_data[i]), exp_d[i]);
      end
    end
  endtask

  task automatic test_odd_dims();
    logic [17:0] ea;
    logic [31:0] ed;
    int          k = 0;
    for (int z = 0; z < 2; z++)
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 5; x++)
          if (x == 4 || y == 4) dram[IFB + z*1024 + y*32 + x] = 32'h7FFF_FFFF;
          else dram[IFB + z*1024 + y*32 + x] = pix3(z, y, x);
    clear_mon();
    start_run(5, 5, 2, 1'b0);
    cfg_width = 6'd2;  // must be ignored while running
    cfg_mode  = 1'b1;
    wait_done(3000, "odd_dims");
    tests++;
    if (wr_addr.size() != 8) begin
      fails++;
      $display("FAIL odd_wr_count: got %0d writes, required 8", wr_addr.size());
    end
    tests++;
    if (bad_reads != 0 || beats != 32) begin
      fails++;
      $display("FAIL odd_reads: %0d reads at x/y=4 and %0d beats, required 0 and 32",
               bad_reads, beats);
    end
    for (int z = 0; z < 2; z++)
      for (int y = 0; y < 4; y += 2)
        for (int x = 0; x < 4; x += 2) begin
          ea = 18'(OFB + z*1024 + (y/2)*32 + x/2);
          ed = ref_pool(z, y, x, 1'b0);
          if (k < wr_addr.size()) begin
            tests++;
            if (wr_addr[k] !== ea || wr_data[k] !== ed) begin
              fails++;
              $display("FAIL odd_wr%0d: addr=%0d data=%0d, required addr=%0d data=%0d",
                       k, wr_addr[k], $signed(wr_data[k]), ea, $signed(ed));
            end
          end
          k++;
        end
    base_addr = wr_addr;
    base_data = wr_data;
  endtask

  task automatic test_random_latency();
    rand_lat = 1'b1;
    clear_mon();
    start_run(5, 5, 2, 1'b0);
    wait_done(5000, "rand_lat");
    rand_lat = 1'b0;
    wait_cnt = 0;
    tests++;
    if (wr_addr.size() != base_addr.size() || wr_addr.size() != 8) begin
      fails++;
      $display("FAIL lat_wr_count: got %0d writes, required 8", wr_addr.size());
    end
    for (int i = 0; i < wr_addr.size() && i < base_addr.size(); i++) begin
      tests++;
      if (wr_addr[i] !== base_addr[i] || wr_data[i] !== base_data[i]) begin
        fails++;
        $display("FAIL lat_wr%0d: addr=%0d data=%0d, required addr=%0d data=%0d",
                 i, wr_addr[i], $signed(wr_data[i]), base_addr[i], $signed(base_data[i]));
      end
    end
    tests++;
    if (unstable != 0) begin
      fails++;
      $display("FAIL lat_stable: %0d unstable request cycles, required 0", unstable);
    end
    tests++;
    if (stall_cycles == 0) begin
      fails++;
      $display("FAIL lat_stalls: %0d stall cycles, required >0", stall_cycles);
    end
  endtask

  task automatic test_degenerate();
    int ws[2] = '{1, 4};
    int ds[2] = '{1, 0};
    for (int k = 0; k < 2; k++) begin
      clear_mon();
      @(negedge clk);
      cfg_width = 6'(ws[k]); cfg_height = 6'd4; cfg_depth = 5'(ds[k]);
      enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
      tests++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL degen%0d_ldcfg: busy=%b done=%b, required busy=1 done=0", k, busy, done);
      end
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || done !== 1'b1) begin
        fails++;
        $display("FAIL degen%0d_done: busy=%b done=%b, required busy=0 done=1", k, busy, done);
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || rd_cycles != 0 || wr_addr.size() != 0) begin
        fails++;
        $display("FAIL degen%0d_quiet: done=%b rd_cycles=%0d writes=%0d, required 0/0/0",
                 k, done, rd_cycles, wr_addr.size());
      end
    end
  endtask

  task automatic test_reset_midrun();
    int img[16] = '{-5, -2, 10, 3,  -9, -3, 4, 10,  0, 0, -1, -7,  0, -1, -8, -1};
    int exp_a[4] = '{65536, 65537, 65568, 65569};
    int exp_d[4] = '{-2, 10, 0, -1};
    int n = 0;
    load_img4(img);
    clear_mon();
    start_run(4, 4, 1, 1'b0);
    while (beats < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (beats < 2) begin
      fails++;
      $display("FAIL rst_beats: %0d beats before reset, required 2", beats);
    end
    @(posedge clk);
    #2 srstn = 1'b0;
    #1;
    tests++;
    if ({dram_en_rd, dram_en_wr, busy, done} !== 4'b0 || addr_in !== 18'd0) begin
      fails++;
      $display("FAIL rst_async_rd: rd/wr/busy/done=%b addr_in=%0d, required 0",
               {dram_en_rd, dram_en_wr, busy, done}, addr_in);
    end
    tests++;
    if (addr_out !== 18'd0 || data_out !== 32'd0) begin
      fails++;
      $display("FAIL rst_async_wr: addr_out=%0d data_out=%0d, required 0", addr_out, data_out);
    end
    repeat (3) @(negedge clk);
    srstn = 1'b1;
    tests++;
    if (wr_addr.size() != 0) begin
      fails++;
      $display("FAIL rst_no_write: %0d writes around reset, required 0", wr_addr.size());
    end
    clear_mon();
    start_run(4, 4, 1, 1'b0);
    wait_done(2000, "rst_rerun");
    tests++;
    if (wr_addr.size() != 4) begin
      fails++;
      $display("FAIL rst_rerun_count: got %0d writes, required 4", wr_addr.size());
    end
    for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
      tests++;
      if (wr_addr[i] !== 18'(exp_a[i]) || wr_data[i] !== 32'(exp_d[i])) begin
        fails++;
        $display("FAIL rst_rerun_wr%0d: addr=%0d data=%0d, required addr=%0d data=%0d",
                 i, wr_addr[i], $signed(wr_data[i]), exp_a[i], exp_d[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_max_basic();
    test_avg();
    test_odd_dims();
    test_random_latency();
    test_degenerate();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
